// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: access-size encodings, MEM-stage FSM states,
// width constants and the byte-enable helper used for lane steering.
package mips_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_G,
    WAIT_R
  } mem_state_e;

  // Big-endian lanes: be[3] is byte 0 of the word.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] o);
    case (size)
      SZ_BYTE: return 4'b1000 >> o;
      SZ_HALF: return o[1] ? 4'b0011 : 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/gnt/rvalid bus between the MEM stage (master) and memory (slave).
interface mem_stage_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-3:0] dmem_addr;
  logic [3:0]    dmem_be;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_gnt;
  logic          dmem_rvalid;
  logic [DW-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_load_align.sv
// Combinational big-endian byte/half lane extract with sign or zero extension.
module mem_load_align
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      size,
  input  logic [1:0]      offset,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = '0;
    h    = '0;
    data = rdata;
    case (offset)
      2'd0:    b = rdata[31:24];
      2'd1:    b = rdata[23:16];
      2'd2:    b = rdata[15:8];
      default: b = rdata[7:0];
    endcase
    h = offset[1] ? rdata[15:0] : rdata[31:16];
    case (size)
      SZ_BYTE: data = {{24{~is_unsigned & b[7]}}, b};
      SZ_HALF: data = {{16{~is_unsigned & h[15]}}, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: data-memory handshake FSM, store steering, load alignment and
// the MEM/WB register. Define MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_stage
  import mips_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [AW-1:0]      in_alu_result,
  input  logic [DW-1:0]      in_store_data,
  input  logic [REG_AW-1:0]  in_rd,
  input  logic               in_reg_write,
  input  logic               in_mem_read,
  input  logic               in_mem_write,
  input  logic [1:0]         in_mem_size,
  input  logic               in_mem_unsigned,
  output logic               mem_stall,
  mem_stage_if.master        dmem,
  output logic               wb_valid,
  output logic               wb_reg_write,
  output logic [REG_AW-1:0]  wb_rd,
  output logic [DW-1:0]      wb_data,
  output logic               exc_misalign
);

  mem_state_e    state, state_nxt;
  logic          mem_op, is_store, trap, go, req, done;
  logic [1:0]    off;
  logic [DW-1:0] load_data, wdata;

  assign mem_op   = in_valid & (in_mem_read | in_mem_write);
  assign is_store = in_mem_write;

`ifdef MISALIGN_TRAP_EN
  assign trap = mem_op &
                (((in_mem_size == SZ_HALF) & in_alu_result[0]) |
                 (in_mem_size[1] & (in_alu_result[1:0] != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  assign go = mem_op & ~trap;

  // Effective offset with misaligned low bits forced to zero.
  always_comb begin
    case (in_mem_size)
      SZ_BYTE: off = in_alu_result[1:0];
      SZ_HALF: off = {in_alu_result[1], 1'b0};
      default: off = 2'b00;
    endcase
  end

  always_comb begin
    case (in_mem_size)
      SZ_BYTE: wdata = {4{in_store_data[7:0]}};
      SZ_HALF: wdata = {2{in_store_data[15:0]}};
      default: wdata = in_store_data;
    endcase
  end

  always_comb begin
    req       = 1'b0;
    done      = 1'b0;
    state_nxt = state;
    case (state)
      IDLE, WAIT_G: begin
        req = go;
        if (go && dmem.dmem_gnt) begin
          done      = is_store;
          state_nxt = is_store ? IDLE : WAIT_R;
        end else begin
          state_nxt = go ? WAIT_G : IDLE;
        end
      end
      WAIT_R: begin
        done      = dmem.dmem_rvalid;
        state_nxt = dmem.dmem_rvalid ? IDLE : WAIT_R;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_stall       = go & ~done;
  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = req & is_store;
  assign dmem.dmem_addr  = req ? in_alu_result[AW-1:2] : '0;
  assign dmem.dmem_be    = req ? lane_be(in_mem_size, off) : '0;
  assign dmem.dmem_wdata = (req & is_store) ? wdata : '0;

  mem_load_align u_align (
    .rdata       (dmem.dmem_rdata),
    .size        (in_mem_size),
    .offset      (off),
    .is_unsigned (in_mem_unsigned),
    .data        (load_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      exc_misalign <= 1'b0;
    end else begin
      state <= state_nxt;
      if (mem_stall) begin
        wb_valid     <= 1'b0;
        wb_reg_write <= 1'b0;
        exc_misalign <= 1'b0;
      end else begin
        wb_valid     <= in_valid;
        wb_reg_write <= in_valid & in_reg_write & ~trap;
        wb_rd        <= in_rd;
        wb_data      <= (go & ~is_store) ? load_data : in_alu_result;
        exc_misalign <= trap;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with hand-computed expectations.
module tb_mem_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_alu_result;
  logic [31:0] in_store_data;
  logic [4:0]  in_rd;
  logic        in_reg_write, in_mem_read, in_mem_write, in_mem_unsigned;
  logic [1:0]  in_mem_size;
  logic        mem_stall;
  logic        wb_valid, wb_reg_write, exc_misalign;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  mem_stage_if #(.AW(32), .DW(32)) bus ();

  mem_stage #(.AW(32), .DW(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_alu_result   (in_alu_result),
    .in_store_data   (in_store_data),
    .in_rd           (in_rd),
    .in_reg_write    (in_reg_write),
    .in_mem_read     (in_mem_read),
    .in_mem_write    (in_mem_write),
    .in_mem_size     (in_mem_size),
    .in_mem_unsigned (in_mem_unsigned),
    .mem_stall       (mem_stall),
    .dmem            (bus),
    .wb_valid        (wb_valid),
    .wb_reg_write    (wb_reg_write),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .exc_misalign    (exc_misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic v, input logic [31:0] a, input logic [31:0] sd,
                    input logic [4:0] rd, input logic rw, input logic mr,
                    input logic mw, input logic [1:0] sz, input logic u);
    in_valid = v; in_alu_result = a; in_store_data = sd; in_rd = rd;
    in_reg_write = rw; in_mem_read = mr; in_mem_write = mw;
    in_mem_size = sz; in_mem_unsigned = u;
  endtask

  task automatic idle_in();
    op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0);
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'h0;
  endtask

  // Load granted in its first cycle; rvalid arrives lat cycles after gnt.
  task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic u, input logic [31:0] rdata, input int lat,
                         input logic [31:0] exp);
    @(negedge clk);
    op(1'b1, a, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, sz, u);
    bus.dmem_gnt = 1'b1;
    #1 chk({tag, "_req"}, {31'b0, bus.dmem_req}, 32'd1);
    chk({tag, "_stall0"}, {31'b0, mem_stall}, 32'd1);
    @(posedge clk); #1 chk({tag, "_bubble"}, {31'b0, wb_valid}, 32'd0);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk); bus.dmem_gnt = 1'b0;
      #1 chk({tag, "_waitr_stall"}, {31'b0, mem_stall}, 32'd1);
      chk({tag, "_waitr_req"}, {31'b0, bus.dmem_req}, 32'd0);
    end
    @(negedge clk);
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = rdata;
    #1 chk({tag, "_done_stall"}, {31'b0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_wb_data"}, wb_data, exp);
    chk({tag, "_wb_valid"}, {31'b0, wb_valid}, 32'd1);
    chk({tag, "_wb_rw"}, {31'b0, wb_reg_write}, 32'd1);
    @(negedge clk); idle_in();
  endtask

  initial begin
    reset = 1'b0;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_wb_rw", {31'b0, wb_reg_write}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_exc", {31'b0, exc_misalign}, 32'd0);
    chk("rst_req", {31'b0, bus.dmem_req}, 32'd0);
    chk("rst_stall", {31'b0, mem_stall}, 32'd0);

    // ALU op passes straight through
    @(negedge clk); reset = 1'b1;
    op(1'b1, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, SZ_WORD, 1'b0);
    #1 chk("alu_stall", {31'b0, mem_stall}, 32'd0);
    chk("alu_req", {31'b0, bus.dmem_req}, 32'd0);
    @(posedge clk); #1;
    chk("alu_wb_data", wb_data, 32'h1234);
    chk("alu_wb_rd", {27'b0, wb_rd}, 32'd5);
    chk("alu_wb_rw", {31'b0, wb_reg_write}, 32'd1);

    // SB 0x101 with gnt withheld two cycles
    @(negedge clk);
    op(1'b1, 32'h101, 32'hAB, 5'd0, 1'b0, 1'b0, 1'b1, SZ_BYTE, 1'b0);
    bus.dmem_gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("sb_stall", {31'b0, mem_stall}, 32'd1);
      chk("sb_req", {31'b0, bus.dmem_req}, 32'd1);
      chk("sb_we", {31'b0, bus.dmem_we}, 32'd1);
      chk("sb_be", {28'b0, bus.dmem_be}, 32'b0100);
      chk("sb_wdata", bus.dmem_wdata, 32'hABABABAB);
      chk("sb_addr", {2'b0, bus.dmem_addr}, 32'h40);
      @(posedge clk); #1 chk("sb_bubble", {31'b0, wb_valid}, 32'd0);
    end
    @(negedge clk); bus.dmem_gnt = 1'b1;
    #1 chk("sb_gnt_stall", {31'b0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    chk("sb_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("sb_wb_rw", {31'b0, wb_reg_write}, 32'd0);
    chk("sb_wb_data", wb_data, 32'h101);

    // SH 0x102, granted immediately: no stall
    @(negedge clk);
    op(1'b1, 32'h102, 32'h5555CAFE, 5'd0, 1'b0, 1'b0, 1'b1, SZ_HALF, 1'b0);
    bus.dmem_gnt = 1'b1;
    #1 chk("sh_stall", {31'b0, mem_stall}, 32'd0);
    chk("sh_be", {28'b0, bus.dmem_be}, 32'b0011);
    chk("sh_wdata", bus.dmem_wdata, 32'hCAFECAFE);
    @(posedge clk); #1 chk("sh_wb_valid", {31'b0, wb_valid}, 32'd1);
    @(negedge clk); idle_in();

    do_load("lb", 32'h102, SZ_BYTE, 1'b0, 32'h1122F344, 3, 32'hFFFFFFF3);
    do_load("lbu", 32'h102, SZ_BYTE, 1'b1, 32'h1122F344, 1, 32'h000000F3);
    do_load("lh0", 32'h200, SZ_HALF, 1'b0, 32'h80017FFF, 1, 32'hFFFF8001);
    do_load("lh2", 32'h202, SZ_HALF, 1'b0, 32'h80017FFF, 2, 32'h00007FFF);

    // Reset while waiting for read data
    @(negedge clk);
    op(1'b1, 32'h300, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0);
    bus.dmem_gnt = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.dmem_gnt = 1'b0;
    #1 chk("rstw_stall_pre", {31'b0, mem_stall}, 32'd1);
    reset = 1'b0;
    @(posedge clk); #1 chk("rstw_wb_valid", {31'b0, wb_valid}, 32'd0);
    @(negedge clk); reset = 1'b1; in_valid = 1'b0;
    #1 chk("rstw_stall", {31'b0, mem_stall}, 32'd0);
    chk("rstw_req", {31'b0, bus.dmem_req}, 32'd0);
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h12345678;
    @(posedge clk); #1;
    chk("rstw_stale_valid", {31'b0, wb_valid}, 32'd0);
    chk("rstw_stale_rw", {31'b0, wb_reg_write}, 32'd0);
    @(negedge clk); idle_in();

    // LW at misaligned 0x103
    @(negedge clk);
    op(1'b1, 32'h103, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0);
    bus.dmem_gnt = 1'b0;
`ifdef MISALIGN_TRAP_EN
    #1 chk("lwm_req", {31'b0, bus.dmem_req}, 32'd0);
    chk("lwm_stall", {31'b0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    chk("lwm_exc", {31'b0, exc_misalign}, 32'd1);
    chk("lwm_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("lwm_wb_rw", {31'b0, wb_reg_write}, 32'd0);
    chk("lwm_wb_data", wb_data, 32'h103);
`else
    #1 chk("lwm_req", {31'b0, bus.dmem_req}, 32'd1);
    chk("lwm_addr", {2'b0, bus.dmem_addr}, 32'h40);
    chk("lwm_be", {28'b0, bus.dmem_be}, 32'b1111);
    @(posedge clk);
    @(negedge clk); bus.dmem_gnt = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    chk("lwm_wb_data", wb_data, 32'hDEADBEEF);
    chk("lwm_exc", {31'b0, exc_misalign}, 32'd0);
`endif
    @(negedge clk); idle_in();
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline, directly downstream of the EX/MEM register.
- Takes the EX/MEM fields and performs load/store accesses to data memory over a req/gnt/rvalid handshake, including byte-lane steering and sign/zero extension.
- Drives the stall that freezes upstream stages while an access is outstanding.
- Contains the MEM/WB pipeline register; its outputs feed writeback.

Parameters:
- AW, 32, byte-address width
- DW, 32, data width; fixed at 32, other values unsupported

Ports:
- clk, in, 1, clock
- reset, in, 1, synchronous, active-low reset
- in_valid, in, 1, EX/MEM slot holds a real instruction
- in_alu_result, in, 32, effective address, or ALU result for non-memory ops
- in_store_data, in, 32, rt value for stores
- in_rd, in, 5, destination register
- in_reg_write, in, 1, instruction writes the register file
- in_mem_read, in, 1, load
- in_mem_write, in, 1, store
- in_mem_size, in, 2, 00 byte, 01 half, 10 word, 11 treated as word
- in_mem_unsigned, in, 1, zero-extend loads (LBU/LHU)
- mem_stall, out, 1, hold upstream registers (drives their LD low)
- dmem_req, out, 1, access request
- dmem_we, out, 1, write enable
- dmem_addr, out, 30, word address (addr[31:2])
- dmem_be, out, 4, byte enables; be[3] = byte 0 (big-endian)
- dmem_wdata, out, 32, write data
- dmem_gnt, in, 1, request accepted this cycle
- dmem_rvalid, in, 1, read data valid
- dmem_rdata, in, 32, read data
- wb_valid, out, 1, MEM/WB slot valid
- wb_reg_write, out, 1, writeback enable
- wb_rd, out, 5, writeback register
- wb_data, out, 32, load result or ALU result
- exc_misalign, out, 1, misaligned access flag (MEM/WB-aligned)

Behaviour:
- Reset (reset=0 at posedge):
  - FSM returns to IDLE.
  - All wb_* outputs and exc_misalign become 0.
  - Combinational dmem_* outputs are 0 while in IDLE with no mem op.
- A memory op is `in_valid & (in_mem_read | in_mem_write)`. If both read and write are set, the op is treated as a store.
- FSM states: IDLE, WAIT_G, WAIT_R.
  - IDLE with a mem op:
    - dmem_req=1 combinationally.
    - gnt=1 and store: complete this cycle.
    - gnt=1 and load: go to WAIT_R.
    - gnt=0: go to WAIT_G.
  - WAIT_G: dmem_req, dmem_addr, dmem_we, dmem_be and dmem_wdata held stable until gnt. Transitions on gnt are the same as in IDLE.
  - WAIT_R: dmem_req=0. On rvalid, complete and return to IDLE. rvalid arriving in IDLE or WAIT_G is ignored.
- mem_stall is 1 on every cycle with a mem op that does not complete that cycle; it is combinational. Upstream must hold all in_* stable while mem_stall=1.
- Latency:
  - Non-memory instructions: 1 cycle, no stall.
  - Store with gnt in the first cycle: 1 cycle, no stall.
  - Load: minimum 2 cycles (rvalid no earlier than the cycle after gnt).
- MEM/WB register (updated every posedge when reset=1):
  - Stalled cycle: load a bubble (wb_valid=0, wb_reg_write=0, exc_misalign=0).
  - Otherwise capture wb_valid=in_valid, wb_reg_write=in_valid&in_reg_write, wb_rd=in_rd.
  - wb_data = extracted load data for loads, in_alu_result otherwise.
- Store steering, with o = addr[1:0]:
  - Byte: wdata = {4{store[7:0]}}, be = 4'b1000>>o.
  - Half: wdata = {2{store[15:0]}}, be = 1100 if o[1]=0, else 0011.
  - Word: be = 1111.
- Load extraction:
  - Byte o=0 selects rdata[31:24]; byte o=3 selects rdata[7:0].
  - Half o[1]=0 selects [31:16], else [15:0].
  - Sign-extend, or zero-extend if in_mem_unsigned.
- Misalignment (half with addr[0]=1, word with addr[1:0]≠0), without the optional feature:
  - Offending low bits are forced to 0 and the access proceeds aligned.
  - exc_misalign stays 0.
- Reset mid-access: the FSM aborts to IDLE. The memory side must be reset by the same signal; a stale rvalid is ignored.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: a misaligned mem op issues no request (dmem_req=0) and does not stall. The next edge loads wb_valid=1, wb_reg_write=0, exc_misalign=1 and wb_data=in_alu_result (bad address).
- Undefined: addresses are force-aligned as above; exc_misalign is tied 0.

Decomposition:
- Package mips_pkg:
  - Size encodings: SZ_BYTE, SZ_HALF, SZ_WORD.
  - FSM state enum.
  - Width constants: REG_AW=5, XLEN=32.
- Sub-module mem_load_align: combinational byte-lane extract plus sign/zero extension, reusable for instruction-side byte access.

Test Plan:
- ALU op, in_alu_result=0x1234, rd=5, reg_write=1: mem_stall=0; next cycle wb_data=0x1234, wb_rd=5, wb_reg_write=1.
- SB, addr=0x101, store=0xAB, gnt held 0 for 2 cycles: mem_stall=1 for 2 cycles with dmem_be=0100, wdata=0xABABABAB, dmem_addr=0x40 stable. Completes in the gnt cycle; bubbles appear on wb while stalled.
- LB, addr=0x102, rdata=0x1122F344, rvalid 3 cycles after gnt: wb_data=0xFFFFFFF3. Same access as LBU: 0x000000F3.
- LH, addr=0x200, rdata=0x80017FFF: wb_data=0xFFFF8001. At addr=0x202 the result is 0x00007FFF.
- Reset asserted in WAIT_R: FSM returns to IDLE, wb_valid=0, mem_stall=0; a following rvalid pulse produces no writeback.
- LW at addr=0x103:
  - With MISALIGN_TRAP_EN: no dmem_req, exc_misalign=1, wb_reg_write=0, wb_data=0x103.
  - Without the macro: dmem_addr=0x40, be=1111.
